pc_sequencer: RTL and testbench

//  Parametrised next-PC sequencer for the fetch stage. Holds the architectural fetch PC.

---
 rtl/pc_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and vectored interrupt sequencing for fetch.
// Optional feature macro: PC_MISALIGN_TRAP_EN adds the misalign output and
// traps misaligned redirect targets to VECTOR_BASE-VECTOR_STRIDE.
module pc_sequencer #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NUM_IRQ       = 4,
  parameter int unsigned     DRAIN_CYCLES  = 3,
  parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
  parameter logic [XLEN-1:0] VECTOR_BASE   = XLEN'('h100),
  parameter logic [XLEN-1:0] VECTOR_STRIDE = XLEN'('h10),
  localparam int unsigned    ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_undo,
  input  logic [XLEN-1:0]    pc_not_taken,
  input  logic               pcr_take,
  input  logic [XLEN-1:0]    pcr,
  input  logic               branch_predict,
  input  logic [XLEN-1:0]    branch_pc,
  input  logic               pci_take,
  input  logic [XLEN-1:0]    pci,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               irq_mask,
  input  logic               rti,
  output logic [XLEN-1:0]    pc,
  output logic               flush,
  output logic               irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic [XLEN-1:0]    epc,
  output logic               in_isr
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic               misalign
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_VECTOR = 2'd2,
    S_ISR    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   nxt;
  logic [XLEN-1:0]   vec_addr;
  logic [ID_W-1:0]   irq_sel;
  logic              irq_take;
  logic [XLEN-1:0]   pc_d, epc_d;
  logic [ID_W-1:0]   irq_id_d;
  logic              flush_d, irq_ack_d, in_isr_d;
`ifdef PC_MISALIGN_TRAP_EN
  logic              redirect;
  logic              mis_c;
  logic              misalign_d;
`endif

  // Priority next-PC select: stall > undo > pcr > predict > pci > pc+4
  always_comb begin
    nxt = pc + XLEN'(4);
    if (stall)               nxt = pc;
    else if (branch_undo)    nxt = pc_not_taken;
    else if (pcr_take)       nxt = pcr;
    else if (branch_predict) nxt = branch_pc;
    else if (pci_take)       nxt = pci;
  end

  // Lowest-numbered pending channel wins
  always_comb begin
    irq_sel = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_req[i]) irq_sel = ID_W'(i);
    end
  end

  assign irq_take = (|irq_req) && !irq_mask;
  assign vec_addr = VECTOR_BASE + (XLEN'(irq_id) * VECTOR_STRIDE);

`ifdef PC_MISALIGN_TRAP_EN
  // A taken redirect whose target is not word aligned
  assign redirect = !stall && (branch_undo || pcr_take || branch_predict || pci_take);
  assign mis_c    = redirect && (nxt[1:0] != 2'b00);
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc;
    epc_d     = epc;
    irq_id_d  = irq_id;
    flush_d   = 1'b0;
    irq_ack_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      S_RUN: begin
        if (irq_take) begin
          irq_id_d = irq_sel;
          epc_d    = nxt;
          cnt_d    = CNT_W'(DRAIN_CYCLES - 1);
          flush_d  = 1'b1;
          state_d  = S_DRAIN;
`ifdef PC_MISALIGN_TRAP_EN
        end else if (mis_c) begin
          pc_d       = VECTOR_BASE - VECTOR_STRIDE;
          epc_d      = nxt;
          flush_d    = 1'b1;
          misalign_d = 1'b1;
          state_d    = S_ISR;
`endif
        end else begin
          pc_d = nxt;
        end
      end
      S_DRAIN: begin
        flush_d = 1'b1;
        if (cnt_q == '0) begin
          pc_d      = vec_addr;
          irq_ack_d = 1'b1;
          state_d   = S_VECTOR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_VECTOR: begin
        state_d = S_ISR;
      end
      S_ISR: begin
        if (rti) begin
          pc_d    = epc;
          flush_d = 1'b1;
          state_d = S_RUN;
`ifdef PC_MISALIGN_TRAP_EN
        end else if (mis_c) begin
          pc_d       = VECTOR_BASE - VECTOR_STRIDE;
          epc_d      = nxt;
          flush_d    = 1'b1;
          misalign_d = 1'b1;
`endif
        end else begin
          pc_d = nxt;
        end
      end
      default: state_d = S_RUN;
    endcase
    in_isr_d = (state_d == S_ISR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      pc       <= RESET_VECTOR;
      epc      <= '0;
      irq_id   <= '0;
      flush    <= 1'b0;
      irq_ack  <= 1'b0;
      in_isr   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc       <= pc_d;
      epc      <= epc_d;
      irq_id   <= irq_id_d;
      flush    <= flush_d;
      irq_ack  <= irq_ack_d;
      in_isr   <= in_isr_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_undo, pcr_take, branch_predict, pci_take;
  logic [31:0] pc_not_taken, pcr, branch_pc, pci;
  logic [3:0]  irq_req;
  logic        irq_mask, rti;
  logic [31:0] pc, epc;
  logic        flush, irq_ack, in_isr;
  logic [1:0]  irq_id;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        ack;
    logic [1:0]  id;
    logic [31:0] epc;
    logic        isr;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_undo    (branch_undo),
    .pc_not_taken   (pc_not_taken),
    .pcr_take       (pcr_take),
    .pcr            (pcr),
    .branch_predict (branch_predict),
    .branch_pc      (branch_pc),
    .pci_take       (pci_take),
    .pci            (pci),
    .irq_req        (irq_req),
    .irq_mask       (irq_mask),
    .rti            (rti),
    .pc             (pc),
    .flush          (flush),
    .irq_ack        (irq_ack),
    .irq_id         (irq_id),
    .epc            (epc),
    .in_isr         (in_isr)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign       (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, f, act, req);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1ns after the rising edge
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "pc",      pc,                 e.pc);
        cmp(nm, "flush",   32'(flush),         32'(e.fl));
        cmp(nm, "irq_ack", 32'(irq_ack),       32'(e.ack));
        cmp(nm, "irq_id",  32'(irq_id),        32'(e.id));
        cmp(nm, "epc",     epc,                e.epc);
        cmp(nm, "in_isr",  32'(in_isr),        32'(e.isr));
`ifdef PC_MISALIGN_TRAP_EN
        cmp(nm, "misalign", 32'(misalign),     32'(e.mis));
`endif
      end
    end
  end

  // Push the outputs expected after the next rising edge, then advance one cycle
  task automatic step(input string nm, input logic [31:0] p, input logic f, input logic a,
                      input logic [1:0] id, input logic [31:0] e, input logic isr, input logic m);
    exp_t x;
    x.pc = p; x.fl = f; x.ack = a; x.id = id; x.epc = e; x.isr = isr; x.mis = m;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic clr();
    stall = 1'b0; branch_undo = 1'b0; pcr_take = 1'b0; branch_predict = 1'b0;
    pci_take = 1'b0; rti = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr(); irq_req = '0; irq_mask = 1'b0;
    pc_not_taken = '0; pcr = '0; branch_pc = '0; pci = '0;
    @(negedge clk);
    step("reset", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    rst = 1'b0;
    step("idle1", 32'h4, 0, 0, 0, 32'h0, 0, 0);
    step("idle2", 32'h8, 0, 0, 0, 32'h0, 0, 0);
    step("idle3", 32'hC, 0, 0, 0, 32'h0, 0, 0);

    // Redirect priority
    pc_not_taken = 32'h40; pcr = 32'h80; branch_pc = 32'h60; pci = 32'h90;
    stall = 1; branch_undo = 1; pcr_take = 1; branch_predict = 1; pci_take = 1;
    step("stall_all", 32'hC, 0, 0, 0, 32'h0, 0, 0);
    stall = 0;
    step("undo_wins", 32'h40, 0, 0, 0, 32'h0, 0, 0);
    branch_undo = 0;
    step("pcr_wins", 32'h80, 0, 0, 0, 32'h0, 0, 0);
    clr(); pci_take = 1; pci = 32'hFFFF_FFFC;
    step("pci_top", 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0, 0);
    clr();
    step("wrap", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    pci_take = 1; pci = 32'h20;
    step("pci_20", 32'h20, 0, 0, 0, 32'h0, 0, 0);

    // Interrupt beats same-cycle predict; redirect saved in epc
    clr(); irq_req = 4'b0110; branch_predict = 1; branch_pc = 32'h60;
    step("take1", 32'h20, 1, 0, 1, 32'h60, 0, 0);
    clr(); irq_req = '0; stall = 1;
    step("drain1b", 32'h20, 1, 0, 1, 32'h60, 0, 0);
    step("drain1c", 32'h20, 1, 0, 1, 32'h60, 0, 0);
    step("vector1", 32'h110, 1, 1, 1, 32'h60, 0, 0);
    step("isr1_in", 32'h110, 0, 0, 1, 32'h60, 1, 0);
    stall = 0;
    step("isr1_seq", 32'h114, 0, 0, 1, 32'h60, 1, 0);
    irq_req = 4'b0001;
    step("isr1_nonest", 32'h118, 0, 0, 1, 32'h60, 1, 0);
    irq_req = '0; rti = 1; stall = 1; branch_undo = 1; pc_not_taken = 32'h44;
    step("rti1", 32'h60, 1, 0, 1, 32'h60, 0, 0);
    clr();
    step("post_rti1", 32'h64, 0, 0, 1, 32'h60, 0, 0);
    rti = 1;
    step("rti_outside", 32'h68, 0, 0, 1, 32'h60, 0, 0);

    // Masked request is ignored, then taken once unmasked
    clr(); irq_mask = 1; irq_req = 4'b1000;
    step("masked1", 32'h6C, 0, 0, 1, 32'h60, 0, 0);
    step("masked2", 32'h70, 0, 0, 1, 32'h60, 0, 0);
    irq_mask = 0;
    step("take3", 32'h70, 1, 0, 3, 32'h74, 0, 0);
    irq_req = '0;
    step("drain3b", 32'h70, 1, 0, 3, 32'h74, 0, 0);
    step("drain3c", 32'h70, 1, 0, 3, 32'h74, 0, 0);
    step("vector3", 32'h130, 1, 1, 3, 32'h74, 0, 0);
    step("isr3_in", 32'h130, 0, 0, 3, 32'h74, 1, 0);
    rti = 1;
    step("rti3", 32'h74, 1, 0, 3, 32'h74, 0, 0);
    rti = 0;
    step("post_rti3", 32'h78, 0, 0, 3, 32'h74, 0, 0);

    // Reset in the middle of a drain, then a full drain afterwards
    irq_req = 4'b0001;
    step("take0", 32'h78, 1, 0, 0, 32'h7C, 0, 0);
    irq_req = '0;
    step("drain0b", 32'h78, 1, 0, 0, 32'h7C, 0, 0);
    rst = 1;
    step("rst_mid", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    rst = 0; irq_req = 4'b0001;
    step("take0r", 32'h0, 1, 0, 0, 32'h4, 0, 0);
    irq_req = '0;
    step("drain0rb", 32'h0, 1, 0, 0, 32'h4, 0, 0);
    step("drain0rc", 32'h0, 1, 0, 0, 32'h4, 0, 0);
    step("vector0r", 32'h100, 1, 1, 0, 32'h4, 0, 0);
    step("isr0r_in", 32'h100, 0, 0, 0, 32'h4, 1, 0);
    rti = 1;
    step("rti0r", 32'h4, 1, 0, 0, 32'h4, 0, 0);
    rti = 0;
    step("post_rti0r", 32'h8, 0, 0, 0, 32'h4, 0, 0);

`ifdef PC_MISALIGN_TRAP_EN
    pci_take = 1; pci = 32'h42;
    step("misalign", 32'hF0, 1, 0, 0, 32'h42, 1, 1);
    clr();
    step("post_mis", 32'hF4, 0, 0, 0, 32'h42, 1, 0);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
